reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port register file with a per-register scoreboard, for the datapath's operand fetch stage. It has two combinational read ports and one synchronous write port, with optional write-to-read bypass and an optional hardwired-zero register 0. A reserve/write handshake tracks registers with an outstanding result, so issue logic can stall on read-after-write hazards. It is the next-generation register file for the core, generalised in width and depth.

## Interface
Parameters:
- DATA_W, 16, register and data width in bits (≥1)
- ADDR_W, 3, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never becomes busy

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr0_addr  in  ADDR_W  write address
- wr0_data  in  DATA_W  write data
- rd0_addr  in  ADDR_W  read port 0 address
- rd1_addr  in  ADDR_W  read port 1 address
- rd0_data  out  DATA_W  read port 0 data (combinational)
- rd1_data  out  DATA_W  read port 1 data (combinational)
- rd0_busy  out  1  register at rd0_addr has a pending result
- rd1_busy  out  1  register at rd1_addr has a pending result
- rsv_en  in  1  reserve request: mark rsv_addr as pending
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reserve granted this cycle (combinational)
- busy_vec  out  2**ADDR_W  registered scoreboard, bit i = register i pending

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus busy[] of 2**ADDR_W bits.
- Reset (rst_n low, asynchronous): all registers = 0 and busy_vec = 0. Reads then return 0, rdX_busy = 0, rsv_ok = 0 when rsv_en = 0.
- Write: if wr_en is high at a rising edge, reg[wr0_addr] ← wr0_data and busy[wr0_addr] ← 0, unless it is re-reserved in the same cycle (see below). A write to a non-busy register is legal and only updates data.
- Reserve: rsv_ok = rsv_en & (~busy[rsv_addr] | (wr_en & wr0_addr==rsv_addr)). When rsv_ok is high, busy[rsv_addr] ← 1 at the edge. A denied reserve changes nothing; the requester retries.
- Reserve and write to the same address in the same cycle: the data is written and busy ends at 1, because the new reservation wins.
- Read data: reg[rdX_addr]. If BYPASS=1 and wr_en & wr0_addr==rdX_addr, the port returns wr0_data.
- Read busy: busy[rdX_addr]. If BYPASS=1 and a same-address write is in progress this cycle, rdX_busy = 0. If BYPASS=0, rdX_busy reflects the registered busy bit only.
- Both read ports may address the same register; each resolves independently.
- ZERO_R0=1:
  - address 0 reads 0 with busy 0;
  - writes to 0 are dropped;
  - a reserve of 0 is always granted (rsv_ok=1) but never sets busy[0];
  - busy_vec[0] is constant 0.

## Timing
- Read latency is 0 cycles (combinational from address, and from write inputs when BYPASS=1).
- Write latency is 1 cycle: data is visible on non-bypassed reads the cycle after the wr_en edge.
- Reserve: busy_vec and rdX_busy (BYPASS=0) assert the cycle after an rsv_ok edge.
- Reset asserted mid-operation clears storage and busy immediately, without waiting for clk. Writes and reserves in the deassertion cycle are ignored only if rst_n is still low at the edge.
- No output depends on a combinational loop. rsv_ok depends only on rsv_*, wr_* and the busy flops.

## Test plan
- Reset then read all addresses on both ports: every rdX_data = 0, rdX_busy = 0, busy_vec = 0.
- Write 0xA5A5 to r3, read r3 on both ports the next cycle: both return 0xA5A5. With BYPASS=1, same-cycle rd0_addr=3 already returns 0xA5A5.
- Reserve r5 (rsv_ok=1), then reserve r5 again: second rsv_ok = 0, busy_vec[5] = 1. Write 0x1234 to r5: busy_vec[5] = 0 next cycle, rd1_data = 0x1234.
- Same cycle, reserve r2 (busy) and write 0x00FF to r2: rsv_ok = 1; next cycle rd0_data = 0x00FF and busy_vec[2] = 1.
- ZERO_R0=1: write 0xFFFF to r0 and reserve r0: rd0_data = 0, rsv_ok = 1, busy_vec[0] = 0.
- Reserve r7 and write r1=0xBEEF, then pulse rst_n low between edges: outputs clear immediately, with busy_vec = 0 and rd0_data(r1) = 0.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Two-read / one-write register file with a per-register
//             scoreboard (reserve/write handshake) for operand fetch.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic [ADDR_W-1:0]       rd0_addr,
    input  logic [ADDR_W-1:0]       rd1_addr,
    output logic [DATA_W-1:0]       rd0_data,
    output logic [DATA_W-1:0]       rd1_data,
    output logic                    rd0_busy,
    output logic                    rd1_busy,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_ok,
    output logic [(2**ADDR_W)-1:0]  busy_vec
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam int c_PORTS = 2;

    logic [DATA_W-1:0]          r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]         r_busy;

    logic                       w_wr_take;
    logic                       w_wr_hits_rsv;
    logic                       w_rsv_grant;
    logic                       w_rsv_set;
    logic [c_PORTS*DATA_W-1:0]  w_rd_data_flat;
    logic [c_PORTS-1:0]         w_rd_busy_flat;

    // Writes to a hardwired-zero r0 are dropped before they reach storage.
    assign w_wr_take     = wr_en && !(ZERO_R0 && (wr0_addr == '0));
    assign w_wr_hits_rsv = wr_en && (wr0_addr == rsv_addr);

    // A write retiring the busy register in this cycle frees it for re-reservation.
    assign w_rsv_grant   = rsv_en && (!r_busy[rsv_addr] || w_wr_hits_rsv);
    assign w_rsv_set     = w_rsv_grant && !(ZERO_R0 && (rsv_addr == '0));

    assign rsv_ok        = w_rsv_grant;
    assign busy_vec      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_wr_take && (wr0_addr == ADDR_W'(i))) begin
                    r_mem[i]  <= wr0_data;
                    r_busy[i] <= 1'b0;
                end
                // New reservation wins over a same-cycle write completion.
                if (w_rsv_set && (rsv_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < c_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;
        logic              w_fwd;
        logic              w_zero;

        assign w_addr = (p == 0) ? rd0_addr : rd1_addr;
        assign w_fwd  = BYPASS && wr_en && (wr0_addr == w_addr);
        assign w_zero = ZERO_R0 && (w_addr == '0);

        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr];
            if (w_fwd) begin
                w_data = wr0_data;
                w_busy = 1'b0;
            end
            if (w_zero) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign w_rd_data_flat[p*DATA_W +: DATA_W] = w_data;
        assign w_rd_busy_flat[p]                  = w_busy;
    end

    assign rd0_data = w_rd_data_flat[0 +: DATA_W];
    assign rd1_data = w_rd_data_flat[DATA_W +: DATA_W];
    assign rd0_busy = w_rd_busy_flat[0];
    assign rd1_busy = w_rd_busy_flat[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb (bypass and zero-r0 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr0_addr = 3'd0;
    logic [15:0] wr0_data = 16'h0;
    logic [2:0]  rd0_addr = 3'd0;
    logic [2:0]  rd1_addr = 3'd0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = 3'd0;

    logic [15:0] rd0_data_a, rd1_data_a, rd0_data_b, rd1_data_b;
    logic        rd0_busy_a, rd1_busy_a, rd0_busy_b, rd1_busy_b;
    logic        rsv_ok_a, rsv_ok_b;
    logic [7:0]  busy_vec_a, busy_vec_b;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data_a), .rd1_data(rd1_data_a),
        .rd0_busy(rd0_busy_a), .rd1_busy(rd1_busy_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(rsv_ok_a), .busy_vec(busy_vec_a)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data_b), .rd1_data(rd1_data_b),
        .rd0_busy(rd0_busy_b), .rd1_busy(rd1_busy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(rsv_ok_b), .busy_vec(busy_vec_b)
    );

    int nvec = 0;
    int nmis = 0;

    // Reference model: index 0 = bypass build, index 1 = zero-r0 build.
    logic [15:0] m_mem  [2][8];
    logic        m_busy [2][8];

    function automatic bit is_byp(int k); return (k == 0); endfunction
    function automatic bit is_z0(int k);  return (k == 1); endfunction

    function automatic logic [15:0] m_rd(int k, logic [2:0] a);
        if (is_z0(k) && a == 3'd0) return 16'h0;
        if (is_byp(k) && wr_en && wr0_addr == a) return wr0_data;
        return m_mem[k][a];
    endfunction

    function automatic logic m_rb(int k, logic [2:0] a);
        if (is_z0(k) && a == 3'd0) return 1'b0;
        if (is_byp(k) && wr_en && wr0_addr == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic m_ok(int k);
        if (!rsv_en) return 1'b0;
        if (is_z0(k) && rsv_addr == 3'd0) return 1'b1;
        return !m_busy[k][rsv_addr] || (wr_en && wr0_addr == rsv_addr);
    endfunction

    function automatic logic [7:0] m_bv(int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    function automatic logic [63:0] m_exp(int k);
        return {21'h0, m_rd(k, rd0_addr), m_rd(k, rd1_addr),
                m_rb(k, rd0_addr), m_rb(k, rd1_addr), m_ok(k), m_bv(k)};
    endfunction

    function automatic logic [63:0] act_a();
        return {21'h0, rd0_data_a, rd1_data_a, rd0_busy_a, rd1_busy_a, rsv_ok_a, busy_vec_a};
    endfunction

    function automatic logic [63:0] act_b();
        return {21'h0, rd0_data_b, rd1_data_b, rd0_busy_b, rd1_busy_b, rsv_ok_b, busy_vec_b};
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            logic ok;
            ok = m_ok(k);
            if (wr_en && !(is_z0(k) && wr0_addr == 3'd0)) begin
                m_mem[k][wr0_addr]  = wr0_data;
                m_busy[k][wr0_addr] = 1'b0;
            end
            if (ok && !(is_z0(k) && rsv_addr == 3'd0)) m_busy[k][rsv_addr] = 1'b1;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]  = 16'h0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(logic we, logic [2:0] wa, logic [15:0] wd,
                          logic [2:0] r0, logic [2:0] r1, logic re, logic [2:0] ra);
        wr_en = we; wr0_addr = wa; wr0_data = wd;
        rd0_addr = r0; rd1_addr = r1; rsv_en = re; rsv_addr = ra;
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic        re;
        logic [2:0]  ra;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        b0;
        logic        b1;
        logic        ok;
        logic [7:0]  bv;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Expected outputs of the bypass build, sampled before each edge.
        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd0, 1'b0, 3'd0, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h20};
        tbl[5]  = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h20};
        tbl[6]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{1'b1, 3'd2, 16'h00FF, 3'd2, 3'd5, 1'b1, 3'd2, 16'h00FF, 16'h1234, 1'b0, 1'b0, 1'b1, 8'h04};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b0, 3'd0, 16'h00FF, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h04};
        tbl[10] = '{1'b1, 3'd2, 16'h0F0F, 3'd4, 3'd2, 1'b0, 3'd0, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b0, 8'h04};
        tbl[11] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0F0F, 16'hA5A5, 1'b0, 1'b0, 1'b0, 8'h00};

        m_reset();

        // Reset state on every address of both ports.
        #12;
        for (int a = 0; a < 8; a++) begin
            set_in(1'b0, 3'd0, 16'h0, 3'(a), 3'(7 - a), 1'b0, 3'd0);
            #1;
            check("reset_a", act_a(), 64'h0);
            check("reset_b", act_b(), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table against the bypass build; zero-r0 build follows the model.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1, tbl[i].ra == 3'd0 ? tbl[i].re : tbl[i].re, tbl[i].ra);
            #1;
            check($sformatf("tbl%0d_a", i), act_a(),
                  {21'h0, tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1, tbl[i].ok, tbl[i].bv});
            check($sformatf("tbl%0d_b", i), act_b(), m_exp(1));
            @(posedge clk);
            m_update();
        end

        // Zero-r0 build: write and reserve r0 together.
        @(negedge clk);
        set_in(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0);
        #1;
        check("z0_same_cycle", {47'h0, rd0_data_b, rsv_ok_b}, {47'h0, 16'h0000, 1'b1});
        @(posedge clk);
        m_update();
        #1;
        check("z0_after_edge", {40'h0, rd0_data_b, busy_vec_b[0]}, 64'h0);
        check("z0_model_a", act_a(), m_exp(0));

        // Randomized traffic on both builds against the model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            set_in(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                   3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 3'($urandom));
            #1;
            check("rand_a", act_a(), m_exp(0));
            check("rand_b", act_b(), m_exp(1));
            @(posedge clk);
            m_update();
        end

        // Reserve r7 and write r1, then pulse reset between edges.
        @(negedge clk);
        set_in(1'b1, 3'd1, 16'hBEEF, 3'd1, 3'd7, 1'b1, 3'd7);
        @(posedge clk);
        m_update();
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 1'b0, 3'd0);
        #1;
        check("pre_rst_a", act_a(), m_exp(0));
        check("pre_rst_r1", {48'h0, rd0_data_a}, {48'h0, 16'hBEEF});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", {40'h0, rd0_data_a, busy_vec_a}, 64'h0);
        check("async_rst_b", {40'h0, rd0_data_b, busy_vec_b}, 64'h0);
        m_reset();
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            set_in(1'b1, 3'(n + 1), 16'(16'h1111 * (n + 1)), 3'(n + 1), 3'(n), 1'b1, 3'(n + 1));
            #1;
            check("post_rst_a", act_a(), m_exp(0));
            check("post_rst_b", act_b(), m_exp(1));
            @(posedge clk);
            m_update();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
